// File: rtl/fetch_unit_if.sv
// Fetch front-end bus: icache request/response, redirect/halt control and the decode-side head port.
interface fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic              imemREN;
  logic [ADDR_W-1:0] imemaddr;
  logic [WORD_W-1:0] imemload;
  logic              ihit;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              inst_valid;
  logic [WORD_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output imemREN, imemaddr, inst_valid, inst, inst_pc,
    input  imemload, ihit, redirect, redirect_pc, halt, inst_ready
  );

  modport slave (
    input  imemREN, imemaddr, inst_valid, inst, inst_pc,
    output imemload, ihit, redirect, redirect_pc, halt, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: fetch PC, icache request, DEPTH-entry prefetch queue feeding decode.
// Optional stats counters are built when FETCH_STATS_EN is defined.
module fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
  input  logic                     CLK,
  input  logic                     RST,
  fetch_unit_if.master             fif,
  output logic [$clog2(DEPTH):0]   count,
  output logic [31:0]              fetched_cnt,
  output logic [31:0]              flush_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] word;
  } entry_t;

  entry_t            q [DEPTH];
  entry_t            hd;
  logic [ADDR_W-1:0] fpc;
  logic [PW-1:0]     head, tail;
  logic              full, push, pop;

  assign full         = (count == FULL_CNT);
  assign fif.imemREN  = !RST && !fif.halt && !fif.redirect && !full;
  assign fif.imemaddr = fpc;
  // imemREN already excludes reset, redirect and halt, so a discarded ihit never pushes
  assign push         = fif.imemREN && fif.ihit;
  assign pop          = (count != '0) && fif.inst_ready;

  assign hd             = q[head];
  assign fif.inst_valid = (count != '0);
  assign fif.inst       = hd.word;
  assign fif.inst_pc    = hd.pc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fpc   <= PC_INIT;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (fif.redirect) begin
      fpc   <= fif.redirect_pc & ~ADDR_W'(3);
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
        fpc  <= fpc + ADDR_W'(4);
      end
      if (pop) head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset; count gates visibility of stale entries
  always_ff @(posedge CLK) begin
    if (push) q[tail] <= '{pc: fpc, word: fif.imemload};
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetched_cnt <= '0;
      flush_cnt   <= '0;
    end else begin
      if (push)         fetched_cnt <= fetched_cnt + 32'd1;
      if (fif.redirect) flush_cnt   <= flush_cnt + 32'd1;
    end
  end
`else
  assign fetched_cnt = '0;
  assign flush_cnt   = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit (DEPTH=4, PC_INIT=0) plus a wrap/drain sequence.
module tb_fetch_unit;
  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  count;
  logic [31:0] fetched_cnt, flush_cnt;
  int errors = 0;
  int checks = 0;

  fetch_unit_if #(.ADDR_W(32), .WORD_W(32)) fif ();

  fetch_unit #(.ADDR_W(32), .WORD_W(32), .DEPTH(4), .PC_INIT('0)) dut (
    .CLK(CLK), .RST(RST), .fif(fif),
    .count(count), .fetched_cnt(fetched_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  // Instruction memory model: word is a tagged copy of its address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction
  assign fif.imemload = mem_word(fif.imemaddr);

  typedef struct {
    bit          rst, ihit, rdy, redir, halt;
    logic [31:0] rpc;
    bit          ren;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
    int          cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit ihit, bit rdy, bit redir, bit halt, logic [31:0] rpc,
                              bit ren, logic [31:0] addr, bit vld, logic [31:0] pc, int cnt);
    vec_t v;
    v.rst = rst; v.ihit = ihit; v.rdy = rdy; v.redir = redir; v.halt = halt; v.rpc = rpc;
    v.ren = ren; v.addr = addr; v.vld = vld; v.pc = pc; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    int exp_pc, pushes, pops, cyc;
    fif.ihit = 0; fif.inst_ready = 0; fif.redirect = 0; fif.redirect_pc = '0; fif.halt = 0;
    RST = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    check("rst_ren",   0, 32'(fif.imemREN), 0);
    check("rst_addr",  0, fif.imemaddr, 32'h0);
    check("rst_valid", 0, 32'(fif.inst_valid), 0);
    check("rst_count", 0, 32'(count), 0);
    check("rst_fetched", 0, fetched_cnt, 0);
    check("rst_flush",   0, flush_cnt, 0);

    //          rst ihit rdy red hlt rpc        ren addr       vld pc          cnt
    // streaming, one per cycle
    tbl.push_back(mk(0, 1, 1, 0, 0, 32'h0,     1, 32'h00,  0, 32'h0,   0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 32'h0,     1, 32'h04,  1, 32'h00,  1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 32'h0,     1, 32'h08,  1, 32'h04,  1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 32'h0,     1, 32'h0C,  1, 32'h08,  1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,     1, 32'h10,  1, 32'h0C,  1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     1, 32'h10,  0, 32'h0,   0));
    // reset mid-stream, then fill to full with decode stalled
    tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,     0, 32'h10,  0, 32'h0,   0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,     1, 32'h00,  0, 32'h0,   0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,     1, 32'h04,  1, 32'h00,  1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,     1, 32'h08,  1, 32'h00,  2));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,     1, 32'h0C,  1, 32'h00,  3));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,     0, 32'h10,  1, 32'h00,  4));
    // full bubble: pop same cycle still blocks the request
    tbl.push_back(mk(0, 1, 1, 0, 0, 32'h0,     0, 32'h10,  1, 32'h00,  4));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,     1, 32'h10,  1, 32'h04,  3));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,     1, 32'h10,  1, 32'h08,  2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,     1, 32'h10,  1, 32'h0C,  1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,     1, 32'h10,  0, 32'h0,   0));
    // three buffered, redirect with coincident ihit and pop
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,     1, 32'h10,  0, 32'h0,   0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,     1, 32'h14,  1, 32'h10,  1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,     1, 32'h18,  1, 32'h10,  2));
    tbl.push_back(mk(0, 1, 1, 1, 0, 32'h103,   0, 32'h1C,  1, 32'h10,  3));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,     1, 32'h100, 0, 32'h0,   0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 32'h0,     1, 32'h100, 0, 32'h0,   0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,     1, 32'h104, 1, 32'h100, 1));
    // halt with two queued: drain continues, ihit discarded, redirect still lands
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,     1, 32'h104, 0, 32'h0,   0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,     1, 32'h108, 1, 32'h104, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 32'h0,     0, 32'h10C, 1, 32'h104, 2));
    tbl.push_back(mk(0, 1, 1, 0, 1, 32'h0,     0, 32'h10C, 1, 32'h104, 2));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h0,     0, 32'h10C, 1, 32'h108, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 32'h0,     0, 32'h10C, 0, 32'h0,   0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 32'h200,   0, 32'h10C, 0, 32'h0,   0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 32'h0,     0, 32'h200, 0, 32'h0,   0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0,     1, 32'h200, 0, 32'h0,   0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      RST = tbl[i].rst; fif.ihit = tbl[i].ihit; fif.inst_ready = tbl[i].rdy;
      fif.redirect = tbl[i].redir; fif.redirect_pc = tbl[i].rpc; fif.halt = tbl[i].halt;
      #1;
      check("imemREN",  i, 32'(fif.imemREN), 32'(tbl[i].ren));
      check("imemaddr", i, fif.imemaddr, tbl[i].addr);
      check("valid",    i, 32'(fif.inst_valid), 32'(tbl[i].vld));
      check("count",    i, 32'(count), tbl[i].cnt);
      if (tbl[i].vld) begin
        check("inst_pc", i, fif.inst_pc, tbl[i].pc);
        check("inst",    i, fif.inst, mem_word(tbl[i].pc));
      end
    end

    // 10 pushes and 2 redirects since the mid-table reset
`ifdef FETCH_STATS_EN
    check("fetched_cnt", 0, fetched_cnt, 32'd10);
    check("flush_cnt",   0, flush_cnt,   32'd2);
`else
    check("fetched_cnt", 0, fetched_cnt, 32'd0);
    check("flush_cnt",   0, flush_cnt,   32'd0);
`endif

    // 20 fetches, decode ready toggling: pointers wrap, order preserved
    @(negedge CLK);
    RST = 1; fif.ihit = 0; fif.inst_ready = 0; fif.halt = 0; fif.redirect = 0;
    @(negedge CLK);
    RST = 0;
    exp_pc = 0; pushes = 0; pops = 0; cyc = 0;
    while (pops < 20 && cyc < 200) begin
      @(negedge CLK);
      fif.inst_ready = cyc[0];
      fif.ihit = (pushes < 20);
      #1;
      if (fif.imemREN && fif.ihit) pushes++;
      if (fif.inst_valid && fif.inst_ready) begin
        check("wrap_pc",   pops, fif.inst_pc, 32'(exp_pc));
        check("wrap_inst", pops, fif.inst, mem_word(32'(exp_pc)));
        exp_pc += 4;
        pops++;
      end
      cyc++;
    end
    check("wrap_pops", 0, 32'(pops), 32'd20);
    @(negedge CLK);
    fif.ihit = 0; #1;
    check("wrap_count", 0, 32'(count), 32'd0);
    check("wrap_valid", 0, 32'(fif.inst_valid), 32'd0);
    check("wrap_addr",  0, fif.imemaddr, 32'd80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
